mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_word_array.sv | 22 ++
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: 2^WORDS_LOG2 x 16, synchronous write, asynchronous read, no reset.
module mem_word_array #(
    parameter int WORDS_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORDS_LOG2-1:0] idx,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem_q [2**WORDS_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Target end of the memory-request interface: accepts one request, stalls the
// pipeline while it counts down LATENCY cycles, then commits and pulses done.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int WORDS_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    input  logic        halt,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        halted,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    op_e                     op_q, op_d;
    logic [WORDS_LOG2-1:0]   idx_q, idx_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             data_out_q, data_out_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    halt_pend_q, halt_pend_d;

    logic                    commit;
    op_e                     commit_op;
    logic [WORDS_LOG2-1:0]   commit_idx;
    logic [15:0]             commit_data;
    logic [15:0]             arr_rdata;

    logic                    req_legal, req_illegal;
    logic [WORDS_LOG2-1:0]   addr_idx;
    logic                    unused_addr_hi;

    assign req_legal      = (rd ^ wr) & ~addr[0];
    assign req_illegal    = (rd | wr) & ~req_legal;
    assign addr_idx       = addr[WORDS_LOG2:1];
    assign unused_addr_hi = ^(addr >> (WORDS_LOG2 + 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        halt_pend_d = halt_pend_q;
        stall       = 1'b0;
        commit      = 1'b0;
        commit_op   = op_q;
        commit_idx  = idx_q;
        commit_data = wdata_q;

        case (state_q)
            IDLE: begin
                // A halt seen during the previous access is honoured here, in the done cycle.
                if (halt || halt_pend_q) begin
                    state_d     = HALTED;
                    halt_pend_d = 1'b0;
                end else if (req_legal) begin
                    stall = 1'b1;
                    if (LATENCY == 1) begin
                        commit      = 1'b1;
                        commit_op   = wr ? OP_WR : OP_RD;
                        commit_idx  = addr_idx;
                        commit_data = data_in;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                        op_d    = wr ? OP_WR : OP_RD;
                        idx_d   = addr_idx;
                        wdata_d = data_in;
                    end
                end else if (req_illegal) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                stall = (cnt_q != '0);
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                // Commit on the edge that brings the counter to zero so done lands in IDLE.
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            done_d = 1'b1;
            if (commit_op == OP_RD) begin
                data_out_d = arr_rdata;
            end
        end
    end

    mem_word_array #(
        .WORDS_LOG2(WORDS_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (commit && (commit_op == OP_WR)),
        .idx   (commit_idx),
        .wdata (commit_data),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_RD;
            idx_q       <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign err      = err_q;
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_responder;

    localparam int LATENCY    = 4;
    localparam int WORDS_LOG2 = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] data_out;
    logic        done, stall, halted, err;

    mem_responder #(
        .LATENCY    (LATENCY),
        .WORDS_LOG2 (WORDS_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .wr       (wr),
        .halt     (halt),
        .data_out (data_out),
        .done     (done),
        .stall    (stall),
        .halted   (halted),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model state
    bit          m_valid = 0;
    bit          m_halted = 0;
    bit          m_busy = 0;
    bit          m_halt_req = 0;
    int          edge_no = 0;
    int          m_commit_edge = 0;
    bit          m_wr = 0;
    int          m_idx = 0;
    logic [15:0] m_data = '0;
    bit          e_done = 0;
    bit          e_err = 0;
    logic [15:0] e_dout = '0;
    bit          e_dout_known = 0;
    logic [15:0] mem [int];

    // Values observed in the most recent cycle, for directed scenarios
    logic        obs_done, obs_stall, obs_err, obs_halted;
    logic [15:0] obs_dout;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_legal(input logic i_rd, input logic i_wr, input logic [15:0] a);
        return (i_rd ^ i_wr) && !a[0];
    endfunction

    function automatic int word_of(input logic [15:0] a);
        return int'(a[WORDS_LOG2:1]);
    endfunction

    task automatic model_commit(input bit is_wr, input int idx, input logic [15:0] d);
        e_done = 1;
        if (is_wr) mem[idx] = d;
        else if (mem.exists(idx)) begin
            e_dout = mem[idx];
            e_dout_known = 1;
        end else e_dout_known = 0;
    endtask

    task automatic model_step(input logic i_rd, input logic i_wr, input logic [15:0] a,
                              input logic [15:0] d, input logic i_halt, input logic i_rst);
        edge_no++;
        if (i_rst) begin
            m_valid = 1; m_halted = 0; m_busy = 0; m_halt_req = 0;
            e_done = 0; e_err = 0; e_dout = '0; e_dout_known = 1;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (m_halted) begin
                m_halted = 1;
            end else if (m_busy) begin
                if (i_halt) m_halt_req = 1;
                if (edge_no == m_commit_edge) begin
                    m_busy = 0;
                    model_commit(m_wr, m_idx, m_data);
                end
            end else if (i_halt || m_halt_req) begin
                m_halted   = 1;
                m_halt_req = 0;
            end else if (is_legal(i_rd, i_wr, a)) begin
                m_commit_edge = edge_no + LATENCY - 1;
                if (LATENCY == 1) model_commit(i_wr, word_of(a), d);
                else begin
                    m_busy = 1; m_wr = i_wr; m_idx = word_of(a); m_data = d;
                end
            end else if (i_rd || i_wr) begin
                e_err = 1;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cycle(input logic i_rd, input logic i_wr, input logic [15:0] a,
                         input logic [15:0] d, input logic i_halt, input logic i_rst);
        bit e_stall;
        @(negedge clk);
        rd = i_rd; wr = i_wr; addr = a; data_in = d; halt = i_halt; rst = i_rst;
        #1;
        obs_done = done; obs_stall = stall; obs_err = err; obs_halted = halted; obs_dout = data_out;
        if (m_valid) begin
            e_stall = !m_halted && (m_busy ||
                      (!i_halt && !m_halt_req && is_legal(i_rd, i_wr, a)));
            chk("done", {15'd0, done}, {15'd0, e_done});
            chk("err", {15'd0, err}, {15'd0, e_err});
            chk("halted", {15'd0, halted}, {15'd0, m_halted});
            chk("stall", {15'd0, stall}, {15'd0, e_stall});
            if (e_done && e_dout_known) chk("data_out", data_out, e_dout);
        end
        model_step(i_rd, i_wr, a, d, i_halt, i_rst);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    // Issue one request, then idle until done (bounded); report stall count and done cycle.
    task automatic run_req(input logic i_rd, input logic i_wr, input logic [15:0] a,
                           input logic [15:0] d, output int n_stall, output int done_at,
                           output logic [15:0] dout);
        n_stall = 0; done_at = 0; dout = '0;
        cycle(i_rd, i_wr, a, d, 0, 0);
        if (obs_stall) n_stall++;
        for (int k = 2; k <= 12 && done_at == 0; k++) begin
            cycle(0, 0, 16'h0, 16'h0, 0, 0);
            if (obs_stall) n_stall++;
            if (obs_done) begin
                done_at = k;
                dout    = obs_dout;
            end
        end
    endtask

    initial begin
        int          ns, da, cnt;
        logic [15:0] dv;

        // Reset and reset values
        cycle(0, 0, 16'h0, 16'h0, 0, 1);
        cycle(0, 0, 16'h0, 16'h0, 0, 1);
        chk("reset_data_out", obs_dout, 16'h0000);
        chk("reset_done", {15'd0, obs_done}, 16'h0);
        idle(1);

        // Write then read back, checking latency shape
        run_req(0, 1, 16'h0010, 16'hBEEF, ns, da, dv);
        chk("wr_stall_cycles", 16'(ns), 16'd4);
        chk("wr_done_cycle", 16'(da), 16'd5);
        run_req(1, 0, 16'h0010, 16'h0, ns, da, dv);
        chk("rd_done_cycle", 16'(da), 16'd5);
        chk("rd_data", dv, 16'hBEEF);

        // Back-to-back: read presented in the done cycle of a write
        cycle(0, 1, 16'h0020, 16'hA5A5, 0, 0);
        idle(3);
        cycle(1, 0, 16'h0020, 16'h0, 0, 0);
        chk("b2b_wr_done", {15'd0, obs_done}, 16'h1);
        chk("b2b_rd_stall", {15'd0, obs_stall}, 16'h1);
        da = 0;
        for (int k = 1; k <= 10 && da == 0; k++) begin
            cycle(0, 0, 16'h0, 16'h0, 0, 0);
            if (obs_done) begin da = k; dv = obs_dout; end
        end
        chk("b2b_latency", 16'(da), 16'(LATENCY));
        chk("b2b_data", dv, 16'hA5A5);

        // rd and wr together: err pulse, no access
        run_req(0, 1, 16'h0004, 16'h1111, ns, da, dv);
        cycle(1, 1, 16'h0004, 16'h2222, 0, 0);
        chk("both_stall", {15'd0, obs_stall}, 16'h0);
        idle(1);
        chk("both_err", {15'd0, obs_err}, 16'h1);
        idle(1);
        chk("both_err_clear", {15'd0, obs_err}, 16'h0);
        run_req(1, 0, 16'h0004, 16'h0, ns, da, dv);
        chk("both_old_data", dv, 16'h1111);

        // Odd address read: err pulse, never done
        cycle(1, 0, 16'h0003, 16'h0, 0, 0);
        idle(1);
        chk("odd_err", {15'd0, obs_err}, 16'h1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 16'h0, 16'h0, 0, 0);
            if (obs_done) cnt++;
        end
        chk("odd_no_done", 16'(cnt), 16'd0);

        // Reset in the middle of a write abandons it
        run_req(0, 1, 16'h0008, 16'h7777, ns, da, dv);
        cycle(0, 1, 16'h0008, 16'h5555, 0, 0);
        idle(1);
        cycle(0, 0, 16'h0, 16'h0, 0, 1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 16'h0, 16'h0, 0, 0);
            if (obs_done) cnt++;
        end
        chk("rst_no_done", 16'(cnt), 16'd0);
        run_req(1, 0, 16'h0008, 16'h0, ns, da, dv);
        chk("rst_old_data", dv, 16'h7777);

        // Randomized traffic with aliasing addresses, rare halts and resets
        for (int n = 0; n < 3000; n++) begin
            int          r, op;
            logic [15:0] a;
            logic        i_rd, i_wr, i_halt, i_rst;
            r      = int'($urandom_range(0, 999));
            i_rst  = (r < 8);
            i_halt = (r >= 8 && r < 20);
            op     = int'($urandom_range(0, 9));
            i_rd   = (op <= 3) || (op == 8);
            i_wr   = (op >= 4 && op <= 8);
            a      = 16'(($urandom_range(0, 7) << 13) | ($urandom_range(0, 15) << 1));
            if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
            cycle(i_rd, i_wr, a, 16'($urandom), i_halt, i_rst);
        end

        // Halt during an access: finish, pulse done, then halt for good
        cycle(0, 0, 16'h0, 16'h0, 0, 1);
        idle(1);
        cycle(0, 1, 16'h0040, 16'h1234, 0, 0);
        idle(2);
        da = 0; cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 0, 16'h0, 16'h0, 1, 0);
            if (obs_done && da == 0) da = k;
            if (obs_halted && cnt == 0) cnt = k;
        end
        chk("halt_done_seen", 16'(da), 16'd2);
        chk("halt_after_done", 16'(cnt), 16'd3);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, 16'h0040, 16'h0, 0, 0);
            if (obs_done || obs_stall || !obs_halted) cnt++;
        end
        chk("halted_ignores_rd", 16'(cnt), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
